// File: rtl/pi_output_limiter_pkg.sv
// Shared types, constants and arithmetic helpers for the PI output limiter.
package pi_output_limiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic signed [31:0] S32_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] S32_MIN = 32'sh8000_0000;
  localparam int DIFF_W = 33;

  function automatic logic signed [DIFF_W-1:0] sext33(input logic signed [31:0] x);
    return {x[31], x};
  endfunction

  function automatic logic signed [31:0] clamp32(input logic signed [31:0] x,
                                                 input logic signed [31:0] lo,
                                                 input logic signed [31:0] hi);
    logic signed [31:0] r;
    if (x > hi) begin
      r = hi;
    end else if (x < lo) begin
      r = lo;
    end else begin
      r = x;
    end
    return r;
  endfunction

  // Top two bits disagree only when the 33-bit value left the 32-bit range.
  function automatic logic signed [31:0] sat32(input logic signed [DIFF_W-1:0] x);
    logic signed [31:0] r;
    if (x[DIFF_W-1] != x[DIFF_W-2]) begin
      r = x[DIFF_W-1] ? S32_MIN : S32_MAX;
    end else begin
      r = x[31:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/pi_output_limiter_tick_gen.sv
// Update-rate prescaler: counts 0..DIV-1 while enabled and emits a one-cycle tick
// on the last count; srst clears the count synchronously.
module tick_gen #(
  parameter int DIV = 1
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic en,
  input  logic srst,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic          tick_s;

  // Tick on the terminal count while counting is enabled.
  always_comb begin
    tick_s = en && (cnt_r == LAST);
  end

  // Prescaler count register.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      cnt_r <= '0;
    end else if (srst) begin
      cnt_r <= '0;
    end else if (tick_s) begin
      cnt_r <= '0;
    end else if (en) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/pi_output_limiter.sv
// Clamps the PI output to the actuator range at a prescaled rate, produces the
// anti-windup residual, and optionally soft-starts (macro PI_SOFT_START_EN).
module pi_output_limiter
  import pi_output_limiter_pkg::*;
#(
  parameter int                 DIV        = 1,
  parameter logic signed [31:0] OUT_MIN    = -32'sd1000,
  parameter logic signed [31:0] OUT_MAX    = 32'sd1000,
  parameter logic signed [31:0] START_VAL  = 32'sd0,
  parameter logic signed [31:0] SLEW_START = 32'sd1
) (
  input  logic               i_CLK,
  input  logic               i_RST,
  input  logic               i_EN,
  input  logic signed [31:0] i_PI,
  output logic signed [31:0] o_CMD,
  output logic signed [31:0] o_AW,
  output logic               o_VALID,
  output logic               o_SAT_HI,
  output logic               o_SAT_LO,
  output logic               o_RAMP
);

`ifdef PI_SOFT_START_EN
  localparam state_t ENABLE_STATE = ST_RAMP;
`else
  localparam state_t ENABLE_STATE = ST_RUN;
`endif

  state_t state_r, state_nxt_s;

  logic                     tick_s, tg_en_s;
  logic signed [31:0]       clamp_s, step_s, res_s;
  logic signed [DIFF_W-1:0] diff_s, abs_s;
  logic                     within_s;

  logic signed [31:0] cmd_r, cmd_nxt_s;
  logic signed [31:0] aw_r, aw_nxt_s;
  logic               valid_r, valid_nxt_s;
  logic               hi_r, hi_nxt_s;
  logic               lo_r, lo_nxt_s;
  logic               ramp_r, ramp_nxt_s;

  // Counting starts the cycle after the IDLE exit so the first tick lands DIV cycles later.
  assign tg_en_s = i_EN && (state_r != ST_IDLE);

  tick_gen #(.DIV(DIV)) u_tick_gen (
    .i_CLK (i_CLK),
    .i_RST (i_RST),
    .en    (tg_en_s),
    .srst  (~i_EN),
    .tick  (tick_s)
  );

  // Clamp, slew step and residual datapath.
  always_comb begin
    clamp_s  = clamp32(i_PI, OUT_MIN, OUT_MAX);
    diff_s   = sext33(clamp_s) - sext33(cmd_r);
    abs_s    = diff_s[DIFF_W-1] ? -diff_s : diff_s;
    within_s = (abs_s <= sext33(SLEW_START));
    step_s   = diff_s[DIFF_W-1] ? (cmd_r - SLEW_START) : (cmd_r + SLEW_START);
    res_s    = sat32(sext33(i_PI) - sext33(clamp_s));
  end

  // State register.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; dropping the enable always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    if (!i_EN) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: state_nxt_s = ENABLE_STATE;
        ST_RAMP: begin
          if (tick_s && within_s) begin
            state_nxt_s = ST_RUN;
          end else begin
            state_nxt_s = ST_RAMP;
          end
        end
        ST_RUN:  state_nxt_s = ST_RUN;
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Next output values.
  always_comb begin
    cmd_nxt_s   = cmd_r;
    aw_nxt_s    = 32'sd0;
    valid_nxt_s = 1'b0;
    hi_nxt_s    = hi_r;
    lo_nxt_s    = lo_r;
    if (!i_EN) begin
      cmd_nxt_s = START_VAL;
      hi_nxt_s  = 1'b0;
      lo_nxt_s  = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cmd_nxt_s = START_VAL;
          hi_nxt_s  = 1'b0;
          lo_nxt_s  = 1'b0;
        end
        ST_RAMP: begin
          aw_nxt_s = res_s;
          if (tick_s) begin
            valid_nxt_s = 1'b1;
            hi_nxt_s    = (i_PI > OUT_MAX);
            lo_nxt_s    = (i_PI < OUT_MIN);
            cmd_nxt_s   = within_s ? clamp_s : step_s;
          end else begin
            valid_nxt_s = 1'b0;
          end
        end
        ST_RUN: begin
          aw_nxt_s = res_s;
          if (tick_s) begin
            valid_nxt_s = 1'b1;
            hi_nxt_s    = (i_PI > OUT_MAX);
            lo_nxt_s    = (i_PI < OUT_MIN);
            cmd_nxt_s   = clamp_s;
          end else begin
            valid_nxt_s = 1'b0;
          end
        end
        default: begin
          cmd_nxt_s = START_VAL;
          hi_nxt_s  = 1'b0;
          lo_nxt_s  = 1'b0;
        end
      endcase
    end
`ifdef PI_SOFT_START_EN
    ramp_nxt_s = (state_nxt_s == ST_RAMP);
`else
    ramp_nxt_s = 1'b0;
`endif
  end

  // Output registers.
  always_ff @(posedge i_CLK or negedge i_RST) begin
    if (!i_RST) begin
      cmd_r   <= START_VAL;
      aw_r    <= 32'sd0;
      valid_r <= 1'b0;
      hi_r    <= 1'b0;
      lo_r    <= 1'b0;
      ramp_r  <= 1'b0;
    end else begin
      cmd_r   <= cmd_nxt_s;
      aw_r    <= aw_nxt_s;
      valid_r <= valid_nxt_s;
      hi_r    <= hi_nxt_s;
      lo_r    <= lo_nxt_s;
      ramp_r  <= ramp_nxt_s;
    end
  end

  assign o_CMD    = cmd_r;
  assign o_AW     = aw_r;
  assign o_VALID  = valid_r;
  assign o_SAT_HI = hi_r;
  assign o_SAT_LO = lo_r;
  assign o_RAMP   = ramp_r;

endmodule

// File: tb/tb_pi_output_limiter.sv
// Table-driven bench for pi_output_limiter: three parameterisations share one stimulus.
module tb_pi_output_limiter;

`ifdef PI_SOFT_START_EN
  localparam bit SS = 1'b1;
`else
  localparam bit SS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic signed [31:0] pi;

  logic signed [31:0] cmd_o [3];
  logic signed [31:0] aw_o [3];
  logic valid_o [3];
  logic hi_o [3];
  logic lo_o [3];
  logic ramp_o [3];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int dut;
    logic en;
    logic signed [31:0] pi;
    logic valid;
    logic signed [31:0] cmd;
    logic signed [31:0] aw;
    logic hi;
    logic lo;
    logic chk_ramp;
    logic ramp;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  pi_output_limiter #(.DIV(4), .SLEW_START(32'sd100000)) u_a (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_PI(pi),
    .o_CMD(cmd_o[0]), .o_AW(aw_o[0]), .o_VALID(valid_o[0]),
    .o_SAT_HI(hi_o[0]), .o_SAT_LO(lo_o[0]), .o_RAMP(ramp_o[0]));

  pi_output_limiter #(.DIV(1), .SLEW_START(32'sd100)) u_b (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_PI(pi),
    .o_CMD(cmd_o[1]), .o_AW(aw_o[1]), .o_VALID(valid_o[1]),
    .o_SAT_HI(hi_o[1]), .o_SAT_LO(lo_o[1]), .o_RAMP(ramp_o[1]));

  pi_output_limiter #(.DIV(1), .OUT_MIN(32'sh7FFF_FFFD), .OUT_MAX(32'sh7FFF_FFFE),
                      .START_VAL(32'sh7FFF_FFFD), .SLEW_START(32'sd1000)) u_c (
    .i_CLK(clk), .i_RST(rst), .i_EN(en), .i_PI(pi),
    .o_CMD(cmd_o[2]), .o_AW(aw_o[2]), .o_VALID(valid_o[2]),
    .o_SAT_HI(hi_o[2]), .o_SAT_LO(lo_o[2]), .o_RAMP(ramp_o[2]));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", nm,
               $signed(act), act, $signed(exp), exp);
    end
  endtask

  task automatic add(input int d, input logic e, input logic signed [31:0] p,
                     input logic v, input logic signed [31:0] c, input logic signed [31:0] a,
                     input logic h, input logic l, input logic cr, input logic r);
    vec_t t;
    t.dut = d; t.en = e; t.pi = p; t.valid = v; t.cmd = c; t.aw = a;
    t.hi = h; t.lo = l; t.chk_ramp = cr; t.ramp = r;
    tbl.push_back(t);
  endtask

  initial begin
    // DUT A: DIV=4, clamping, enable drop on a tick, re-enable.
    add(0, 1'b0, 32'sd0,     1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 1'b1, 32'sd5000,  1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add(0, 1'b1, 32'sd5000, 1'b0, 32'sd0,    32'sd4000,  1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 1'b1, 32'sd5000,  1'b1, 32'sd1000,  32'sd4000,  1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add(0, 1'b1, -32'sd3000, 1'b0, 32'sd1000, -32'sd2000, 1'b1, 1'b0, 1'b0, 1'b0);
    add(0, 1'b1, -32'sd3000, 1'b1, -32'sd1000, -32'sd2000, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add(0, 1'b1, 32'sd500, 1'b0, -32'sd1000, 32'sd0,     1'b0, 1'b1, 1'b0, 1'b0);
    add(0, 1'b1, 32'sd500,   1'b1, 32'sd500,   32'sd0,     1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++)
      add(0, 1'b1, 32'sd1200, 1'b0, 32'sd500,  32'sd200,   1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 1'b0, 32'sd1200,  1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 1'b0, 32'sd1200,  1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++)
      add(0, 1'b1, -32'sd200, 1'b0, 32'sd0,    32'sd0,     1'b0, 1'b0, 1'b0, 1'b0);
    add(0, 1'b1, -32'sd200,  1'b1, -32'sd200,  32'sd0,     1'b0, 1'b0, 1'b0, 1'b0);

    // DUT B: DIV=1, SLEW=100 soft start (or direct load when compiled out).
    add(1, 1'b0, 32'sd0,     1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b1, 1'b0);
    add(1, 1'b1, 32'sd350,   1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b1, SS);
    add(1, 1'b1, 32'sd350,   1'b1, SS ? 32'sd100 : 32'sd350, 32'sd0, 1'b0, 1'b0, 1'b1, SS);
    add(1, 1'b1, 32'sd350,   1'b1, SS ? 32'sd200 : 32'sd350, 32'sd0, 1'b0, 1'b0, 1'b1, SS);
    add(1, 1'b1, 32'sd350,   1'b1, SS ? 32'sd300 : 32'sd350, 32'sd0, 1'b0, 1'b0, 1'b1, SS);
    add(1, 1'b1, 32'sd350,   1'b1, 32'sd350,   32'sd0,     1'b0, 1'b0, 1'b1, 1'b0);
    add(1, 1'b1, 32'sd420,   1'b1, 32'sd420,   32'sd0,     1'b0, 1'b0, 1'b1, 1'b0);
    add(1, 1'b1, 32'sd1500,  1'b1, 32'sd1000,  32'sd500,   1'b1, 1'b0, 1'b1, 1'b0);
    add(1, 1'b0, -32'sd250,  1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b1, 1'b0);
    add(1, 1'b1, -32'sd250,  1'b0, 32'sd0,     32'sd0,     1'b0, 1'b0, 1'b1, SS);
    add(1, 1'b1, -32'sd250,  1'b1, SS ? -32'sd100 : -32'sd250, 32'sd0, 1'b0, 1'b0, 1'b1, SS);
    add(1, 1'b1, -32'sd250,  1'b1, SS ? -32'sd200 : -32'sd250, 32'sd0, 1'b0, 1'b0, 1'b1, SS);
    add(1, 1'b1, -32'sd250,  1'b1, -32'sd250,  32'sd0,     1'b0, 1'b0, 1'b1, 1'b0);

    // DUT C: limits at the top of the range, residual saturation.
    add(2, 1'b0, 32'sd0,          1'b0, 32'sh7FFF_FFFD, 32'sd0,          1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 1'b1, 32'sh8000_0000,  1'b0, 32'sh7FFF_FFFD, 32'sd0,          1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 1'b1, 32'sh8000_0000,  1'b1, 32'sh7FFF_FFFD, 32'sh8000_0000,  1'b0, 1'b1, 1'b0, 1'b0);
    add(2, 1'b1, 32'sh7FFF_FFFF,  1'b1, 32'sh7FFF_FFFE, 32'sd1,          1'b1, 1'b0, 1'b0, 1'b0);
    add(2, 1'b1, 32'sh7FFF_FFFE,  1'b1, 32'sh7FFF_FFFE, 32'sd0,          1'b0, 1'b0, 1'b0, 1'b0);
    add(2, 1'b0, 32'sd0,          1'b0, 32'sh7FFF_FFFD, 32'sd0,          1'b0, 1'b0, 1'b0, 1'b0);

    rst = 1'b0;
    en  = 1'b0;
    pi  = 32'sd0;
    repeat (3) @(negedge clk);
    check("reset cmd_a", cmd_o[0], 32'sd0);
    check("reset cmd_c", cmd_o[2], 32'sh7FFF_FFFD);
    check("reset valid_a", {31'd0, valid_o[0]}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      int d;
      en = tbl[i].en;
      pi = tbl[i].pi;
      @(posedge clk);
      @(negedge clk);
      d = tbl[i].dut;
      check($sformatf("vec%0d dut%0d valid", i, d), {31'd0, valid_o[d]}, {31'd0, tbl[i].valid});
      check($sformatf("vec%0d dut%0d cmd", i, d), cmd_o[d], tbl[i].cmd);
      check($sformatf("vec%0d dut%0d aw", i, d), aw_o[d], tbl[i].aw);
      check($sformatf("vec%0d dut%0d sat_hi", i, d), {31'd0, hi_o[d]}, {31'd0, tbl[i].hi});
      check($sformatf("vec%0d dut%0d sat_lo", i, d), {31'd0, lo_o[d]}, {31'd0, tbl[i].lo});
      if (tbl[i].chk_ramp)
        check($sformatf("vec%0d dut%0d ramp", i, d), {31'd0, ramp_o[d]}, {31'd0, tbl[i].ramp});
    end

    // Asynchronous reset in the middle of RUN on DUT A.
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    pi = 32'sd5000;
    repeat (6) @(negedge clk);
    check("pre-reset cmd_a", cmd_o[0], 32'sd1000);
    check("pre-reset hi_a", {31'd0, hi_o[0]}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async reset cmd_a", cmd_o[0], 32'sd0);
    check("async reset aw_a", aw_o[0], 32'sd0);
    check("async reset hi_a", {31'd0, hi_o[0]}, 32'd0);
    check("async reset valid_a", {31'd0, valid_o[0]}, 32'd0);
    check("async reset ramp_b", {31'd0, ramp_o[1]}, 32'd0);
    check("async reset cmd_c", cmd_o[2], 32'sh7FFF_FFFD);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("restart cmd_a", cmd_o[0], 32'sd0);
    check("restart valid_a", {31'd0, valid_o[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
